// File: rtl/ir_pkg.sv
// ir_pkg: shared types and constants for the IR transmit scheduler.
//   state_e  - scheduler FSM states
//   frame_t  - latched 35+32-bit NEC-style air-conditioner frame
//   DATA35_W / DATA32_W - frame part widths
//   CLK_HZ, GAP_40MS, TIMEOUT_200MS - timing at the 125 MHz system clock
//   cnt_w()  - counter width helper (never narrower than 1 bit)
package ir_pkg;
  localparam int DATA35_W      = 35;
  localparam int DATA32_W      = 32;
  localparam int ID_W          = 3;
  localparam int CLK_HZ        = 125_000_000;
  localparam int GAP_40MS      = CLK_HZ / 25;
  localparam int TIMEOUT_200MS = CLK_HZ / 5;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_DONE, S_GAP, S_FINISH
  } state_e;

  typedef struct packed {
    logic [DATA35_W-1:0] d35;
    logic [DATA32_W-1:0] d32;
  } frame_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ir_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req  - request vector
//   i_ptr  - highest-priority index this round (< NUM_REQ)
//   o_gnt  - first set request scanning i_ptr, i_ptr+1, ... mod NUM_REQ
//   o_vld  - any request present
module rr_arbiter
  import ir_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_gnt,
  output logic               o_vld
);
  // Offsets are walked from farthest to nearest so the nearest set request
  // is the last write and wins.
  always_comb begin
    o_vld = |i_req;
    o_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (i_req[j] && (j == (int'(i_ptr) + i) % NUM_REQ)) o_gnt = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: shares one IR transmitter among NUM_REQ command sources.
// Grants round-robin, latches the winner's frame, sends it REPEAT times with
// a GAP_CYC idle gap after each frame, then acks (or errs on watchdog abort).
//   i_clk, i_rst_n        - clock, async active-low reset
//   i_req                 - level requests, held until ack/err
//   i_req_data35/32       - per-source frame slices
//   o_ack / o_err         - one-cycle completion / abort pulse to served source
//   o_tx_start            - one-cycle frame start to the transmitter
//   o_tx_data35/32        - latched frame, stable from LOAD until IDLE
//   i_tx_done             - transmitter frame-end pulse
//   o_busy, o_cur_id      - scheduler activity and served source
module ir_tx_scheduler
  import ir_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int REPEAT      = 2,
  parameter int GAP_CYC     = GAP_40MS,
  parameter int TIMEOUT_CYC = TIMEOUT_200MS
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*DATA35_W-1:0] i_req_data35,
  input  logic [NUM_REQ*DATA32_W-1:0] i_req_data32,
  output logic [NUM_REQ-1:0]          o_ack,
  output logic [NUM_REQ-1:0]          o_err,
  output logic                        o_tx_start,
  output logic [DATA35_W-1:0]         o_tx_data35,
  output logic [DATA32_W-1:0]         o_tx_data32,
  input  logic                        i_tx_done,
  output logic                        o_busy,
  output logic [ID_W-1:0]             o_cur_id
);
  localparam int TMO_W = cnt_w(TIMEOUT_CYC);
  localparam int GAP_W = cnt_w(GAP_CYC);
  localparam int REP_W = cnt_w(REPEAT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [REP_W-1:0] REP_N    = REP_W'(REPEAT);

  state_e             r_state, w_nxt;
  logic [ID_W-1:0]    r_rr_ptr, r_cur_id;
  frame_t             r_frame;
  logic [REP_W-1:0]   r_rep_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_abort;

  logic [ID_W-1:0]    w_gnt;
  logic               w_gnt_vld;
  logic               w_tmo;
  logic               w_gap_end;
  logic [NUM_REQ-1:0] w_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req (i_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_vld (w_gnt_vld)
  );

  // A done in the terminal watchdog cycle counts as success.
  assign w_tmo     = (r_state == S_WAIT_DONE) && !i_tx_done && (r_tmo_cnt == TMO_LAST);
  assign w_gap_end = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);
  assign w_sel     = NUM_REQ'(1) << r_cur_id;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (w_gnt_vld) w_nxt = S_LOAD;
      S_LOAD:      w_nxt = S_START;
      S_START:     w_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (i_tx_done || w_tmo) w_nxt = S_GAP;
      S_GAP:       if (w_gap_end) w_nxt = (r_rep_cnt < REP_N && !r_abort) ? S_START : S_FINISH;
      S_FINISH:    w_nxt = S_IDLE;
      default:     w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr  <= '0;
      r_cur_id  <= '0;
      r_frame   <= '0;
      r_rep_cnt <= '0;
      r_tmo_cnt <= '0;
      r_gap_cnt <= '0;
      r_abort   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_gnt_vld) r_cur_id <= w_gnt;
        S_LOAD: begin
          r_frame.d35 <= i_req_data35[r_cur_id*DATA35_W +: DATA35_W];
          r_frame.d32 <= i_req_data32[r_cur_id*DATA32_W +: DATA32_W];
          r_rep_cnt   <= '0;
          r_abort     <= 1'b0;
        end
        S_START: r_tmo_cnt <= '0;
        S_WAIT_DONE: begin
          if (i_tx_done) begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
            r_gap_cnt <= '0;
          end else if (w_tmo) begin
            r_abort   <= 1'b1;
            r_gap_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_GAP: if (!w_gap_end) r_gap_cnt <= r_gap_cnt + 1'b1;
        S_FINISH: r_rr_ptr <= (r_cur_id == ID_W'(NUM_REQ - 1)) ? '0 : r_cur_id + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_tx_start  = (r_state == S_START);
  assign o_busy      = (r_state != S_IDLE);
  assign o_ack       = (r_state == S_FINISH && !r_abort) ? w_sel : '0;
  assign o_err       = w_tmo ? w_sel : '0;
  assign o_tx_data35 = r_frame.d35;
  assign o_tx_data32 = r_frame.d32;
  assign o_cur_id    = r_cur_id;
endmodule
